// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM stream reader.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rr_state_t;

  localparam int RR_FIFO_DEPTH = 4;
  localparam int RR_ROM_LAT    = 1;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready stream carrying the words read out of the ROM.
interface rom_stream_reader_if #(
  parameter int w = 8
);
  logic [w-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/rom_reader_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
module rom_reader_fifo
  import rom_reader_pkg::*;
#(
  parameter int w     = 8,
  parameter int DEPTH = RR_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [w-1:0]  wr_data,
  input  logic          rd_en,
  output logic [w-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [w-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is cleared on reset so the stream data reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/rom_stream_reader.sv
// Reads len consecutive ROM words (wrapping modulo d) and streams them out with backpressure.
// Define ROM_READER_LOOP_EN to repeat the command until stop is raised.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int w  = 8,
  parameter int d  = 16,
  parameter int AW = $clog2(d)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       start_ad,
  input  logic [AW:0]         len,
`ifdef ROM_READER_LOOP_EN
  input  logic                stop,
`endif
  output logic [AW-1:0]       ad_rd,
  input  logic [w-1:0]        data_in,
  rom_stream_reader_if.master m,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(RR_FIFO_DEPTH + 1);

  rr_state_t           state, state_nxt;
  logic [AW-1:0]       ad_nxt, ad_inc;
  logic [AW:0]         len_q, issued_cnt, issued_nxt;
  logic [RR_ROM_LAT:0] inflight_sr;
  logic                issue, pop, fifo_empty, credit_ok;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         occupancy;
  logic [w-1:0]        fifo_rd_data;
`ifdef ROM_READER_LOOP_EN
  logic [AW-1:0]       start_ad_q;
`endif

  assign pop       = !fifo_empty && m.m_ready;
  assign m.m_valid = !fifo_empty;
  assign m.m_data  = fifo_rd_data;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ad_inc    = (ad_rd == AW'(d - 1)) ? '0 : ad_rd + 1'b1;

  // Buffered words plus reads still inside the ROM pipeline must stay within the FIFO depth.
  assign occupancy = (CW + 1)'(fifo_count) + (CW + 1)'($countones(inflight_sr));
  assign credit_ok = (occupancy < (CW + 1)'(RR_FIFO_DEPTH));

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    ad_nxt     = ad_rd;
    issued_nxt = issued_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = RUN;
            issue      = 1'b1;
            ad_nxt     = start_ad;
            issued_nxt = (AW + 1)'(1);
          end
        end
      end
      RUN: begin
`ifdef ROM_READER_LOOP_EN
        if (stop) begin
          state_nxt = DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (issued_cnt == len_q) begin
            ad_nxt     = start_ad_q;
            issued_nxt = (AW + 1)'(1);
          end else begin
            ad_nxt     = ad_inc;
            issued_nxt = issued_cnt + 1'b1;
          end
        end
`else
        if (issued_cnt == len_q) begin
          state_nxt = DRAIN;
        end else if (credit_ok) begin
          issue      = 1'b1;
          ad_nxt     = ad_inc;
          issued_nxt = issued_cnt + 1'b1;
          if (issued_cnt + 1'b1 == len_q) state_nxt = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (inflight_sr == '0 && (fifo_empty || (fifo_count == CW'(1) && pop)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ad_rd       <= '0;
      len_q       <= '0;
      issued_cnt  <= '0;
      inflight_sr <= '0;
`ifdef ROM_READER_LOOP_EN
      start_ad_q  <= '0;
`endif
    end else begin
      state       <= state_nxt;
      ad_rd       <= ad_nxt;
      issued_cnt  <= issued_nxt;
      inflight_sr <= {inflight_sr[RR_ROM_LAT-1:0], issue};
      if (state == IDLE && start) begin
        len_q      <= len;
`ifdef ROM_READER_LOOP_EN
        start_ad_q <= start_ad;
`endif
      end
    end
  end

  // The oldest inflight stage marks a word now present on the ROM output.
  rom_reader_fifo #(
    .w     (w),
    .DEPTH (RR_FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_sr[RR_ROM_LAT]),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader driving a behavioural ROM holding mem[i] = i*3.
module tb_rom_stream_reader;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_ad = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] ad_rd;
  logic [W-1:0]  data_in;
  logic          busy, done;
`ifdef ROM_READER_LOOP_EN
  logic          stop = 1'b0;
`endif

  rom_stream_reader_if #(.w(W)) sif ();

  rom_stream_reader #(.w(W), .d(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_ad (start_ad),
    .len      (len),
`ifdef ROM_READER_LOOP_EN
    .stop     (stop),
`endif
    .ad_rd    (ad_rd),
    .data_in  (data_in),
    .m        (sif),
    .busy     (busy),
    .done     (done)
  );

  logic [W-1:0] rom_mem [D];
  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]  got_q [$];
  logic [AW-1:0] ad_log [$];
  int first_valid_k, done_k, done_cnt, stable_err, valid_cnt;

  always #5 clk = ~clk;

  initial for (int i = 0; i < D; i++) rom_mem[i] = W'(i * 3);

  always @(posedge clk) data_in <= rom_mem[ad_rd];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Issues one command from a negedge and records per-cycle observations; k counts edges after the start edge.
  task automatic applyStimulus(input logic [AW-1:0] sa, input logic [AW:0] ln, input int budget,
                               input int low_from, input int low_len, input int stop_at);
    logic         hold;
    logic [W-1:0] held;
    got_q.delete();
    ad_log.delete();
    first_valid_k = -1;
    done_k        = -1;
    done_cnt      = 0;
    stable_err    = 0;
    valid_cnt     = 0;
    hold          = 1'b0;
    held          = '0;
    start_ad      = sa;
    len           = ln;
    start         = 1'b1;
    sif.m_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      sif.m_ready = !(k >= low_from && k < low_from + low_len);
`ifdef ROM_READER_LOOP_EN
      stop = (k == stop_at);
`endif
      ad_log.push_back(ad_rd);
      if (sif.m_valid) begin
        valid_cnt++;
        if (first_valid_k < 0) first_valid_k = k;
      end
      if (hold && sif.m_data !== held) stable_err++;
      hold = sif.m_valid && !sif.m_ready;
      held = sif.m_data;
      if (sif.m_valid && sif.m_ready) got_q.push_back(sif.m_data);
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      @(negedge clk);
    end
    sif.m_ready = 1'b1;
`ifdef ROM_READER_LOOP_EN
    stop = 1'b0;
`endif
  endtask

  initial begin
    sif.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ad_rd", 32'(ad_rd), 32'd0);
    checkOutput("reset_m_data", 32'(sif.m_data), 32'd0);
    checkOutput("reset_m_valid", 32'(sif.m_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full pass, start_ad=0 len=16");
    applyStimulus(4'd0, 5'd16, 60, -1, 0, -1);
    checkOutput("t1_first_valid", 32'(first_valid_k), 32'd2);
    checkOutput("t1_done_k", 32'(done_k), 32'd18);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_beats", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size() && i < 16; i++)
      checkOutput($sformatf("t1_data%0d", i), 32'(got_q[i]), 32'(i * 3));
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    $display("[TB] wrap, start_ad=14 len=4");
    applyStimulus(4'd14, 5'd4, 30, -1, 0, -1);
    checkOutput("t2_ad0", 32'(ad_log[0]), 32'd14);
    checkOutput("t2_ad1", 32'(ad_log[1]), 32'd15);
    checkOutput("t2_ad2", 32'(ad_log[2]), 32'd0);
    checkOutput("t2_ad3", 32'(ad_log[3]), 32'd1);
    checkOutput("t2_ad_hold", 32'(ad_log[5]), 32'd1);
    checkOutput("t2_beats", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      checkOutput("t2_data0", 32'(got_q[0]), 32'd42);
      checkOutput("t2_data1", 32'(got_q[1]), 32'd45);
      checkOutput("t2_data2", 32'(got_q[2]), 32'd0);
      checkOutput("t2_data3", 32'(got_q[3]), 32'd3);
    end
    checkOutput("t2_done_k", 32'(done_k), 32'd6);

    $display("[TB] backpressure, m_ready low for 10 cycles");
    applyStimulus(4'd0, 5'd16, 90, 4, 10, -1);
    checkOutput("t3_ad_frozen_early", 32'(ad_log[5]), 32'd5);
    checkOutput("t3_ad_frozen_late", 32'(ad_log[13]), 32'd5);
    checkOutput("t3_stable", 32'(stable_err), 32'd0);
    checkOutput("t3_beats", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size() && i < 16; i++)
      checkOutput($sformatf("t3_data%0d", i), 32'(got_q[i]), 32'(i * 3));
    checkOutput("t3_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] zero length command");
    applyStimulus(4'd7, 5'd0, 8, -1, 0, -1);
    checkOutput("t4_done_k", 32'(done_k), 32'd0);
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t4_valid_cnt", 32'(valid_cnt), 32'd0);

    $display("[TB] reset in RUN with two words buffered");
    start_ad    = '0;
    len         = 5'd16;
    sif.m_ready = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_valid_before", 32'(sif.m_valid), 32'd1);
    checkOutput("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(sif.m_valid), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_ad_rd", 32'(ad_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sif.m_ready = 1'b1;
    @(negedge clk);
    applyStimulus(4'd5, 5'd3, 30, -1, 0, -1);
    checkOutput("t5_beats", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      checkOutput("t5_data0", 32'(got_q[0]), 32'd15);
      checkOutput("t5_data1", 32'(got_q[1]), 32'd18);
      checkOutput("t5_data2", 32'(got_q[2]), 32'd21);
    end
    checkOutput("t5_done_k", 32'(done_k), 32'd5);

`ifdef ROM_READER_LOOP_EN
    $display("[TB] loop mode, start_ad=2 len=3, stop later");
    applyStimulus(4'd2, 5'd3, 60, -1, 0, 20);
    checkOutput("t6_enough_beats", 32'(got_q.size() >= 9), 32'd1);
    for (int i = 0; i < got_q.size(); i++)
      checkOutput($sformatf("t6_data%0d", i), 32'(got_q[i]), 32'(6 + 3 * (i % 3)));
    checkOutput("t6_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t6_stable", 32'(stable_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
